// File: rtl/core_bus_avalon.sv
// core_bus_avalon: bridges a single-outstanding core request/ready bus onto an
// Avalon-MM master port, with an optional outstanding-transaction timeout.
//
// state | meaning
// IDLE  | no transaction; a bus_start is accepted here
// ISSUE | avl_read/avl_write driven, waiting for waitrequest to drop
// RESP  | read accepted, waiting for readdatavalid
// DONE  | one-cycle bus_ready pulse (data or timeout completion)
module core_bus_avalon #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] bus_addr,
  input  logic        bus_start,
  input  logic        bus_write,
  input  logic [31:0] bus_data_wr,
  input  logic [3:0]  bus_data_be,
  output logic        bus_ready,
  output logic [31:0] bus_data_rd,
  output logic        bus_timeout,
  output logic        protocol_err,
  output logic [31:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [31:0] avl_writedata,
  output logic [3:0]  avl_byteenable,
  input  logic        avl_waitrequest,
  input  logic        avl_readdatavalid,
  input  logic [31:0] avl_readdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DONE} state_t;

  // Timeout fires in the cycle the counter reaches TIMEOUT-1.
  localparam bit          TO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
  logic        perr_q, perr_d;

  logic [15:0] cnt_sat;
  logic        to_hit;

  assign cnt_sat = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign to_hit  = TO_EN && (cnt_q == TO_LAST);

  // Next-state, request latching, timeout counting and protocol-error detection.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    perr_d    = perr_q;

    if (bus_start && (state_q != IDLE)) begin
      perr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus_start) begin
          addr_d    = bus_addr;
          write_d   = bus_write;
          wdata_d   = bus_data_wr;
          be_d      = bus_data_be;
          rdata_d   = '0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_sat;
        // Acceptance takes priority over a coincident timeout.
        if (!avl_waitrequest) begin
          state_d = write_q ? DONE : RESP;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      RESP: begin
        cnt_d = cnt_sat;
        if (avl_readdatavalid) begin
          rdata_d = avl_readdata;
          state_d = DONE;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      perr_q    <= perr_d;
    end
  end

  // rdata_q is cleared at request start, so write and timeout completions return 0.
  assign bus_ready      = (state_q == DONE);
  assign bus_timeout    = (state_q == DONE) && timeout_q;
  assign bus_data_rd    = (state_q == DONE) ? rdata_q : 32'h0;
  assign protocol_err   = perr_q;
  assign avl_address    = {addr_q, 2'b00};
  assign avl_read       = (state_q == ISSUE) && !write_q;
  assign avl_write      = (state_q == ISSUE) && write_q;
  assign avl_writedata  = wdata_q;
  assign avl_byteenable = be_q;

endmodule

// File: tb/tb_core_bus_avalon.sv
// tb_core_bus_avalon: directed scenarios against core_bus_avalon (TIMEOUT = 4)
// with a transaction-level reference model compared every cycle.
module tb_core_bus_avalon;

  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] bus_addr = '0;
  logic        bus_start = 1'b0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_data_wr = '0;
  logic [3:0]  bus_data_be = '0;
  logic        bus_ready;
  logic [31:0] bus_data_rd;
  logic        bus_timeout;
  logic        protocol_err;
  logic [31:0] avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest = 1'b0;
  logic        avl_readdatavalid = 1'b0;
  logic [31:0] avl_readdata = '0;

  always #5 clk = ~clk;

  core_bus_avalon #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk               (clk),
    .rst               (rst),
    .bus_addr          (bus_addr),
    .bus_start         (bus_start),
    .bus_write         (bus_write),
    .bus_data_wr       (bus_data_wr),
    .bus_data_be       (bus_data_be),
    .bus_ready         (bus_ready),
    .bus_data_rd       (bus_data_rd),
    .bus_timeout       (bus_timeout),
    .protocol_err      (protocol_err),
    .avl_address       (avl_address),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_writedata     (avl_writedata),
    .avl_byteenable    (avl_byteenable),
    .avl_waitrequest   (avl_waitrequest),
    .avl_readdatavalid (avl_readdatavalid),
    .avl_readdata      (avl_readdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: one outstanding transaction, tracked by age in cycles.
  bit          m_busy  = 1'b0;  // transaction outstanding
  bit          m_cmd   = 1'b0;  // command phase (strobe on the bus)
  bit          m_done  = 1'b0;  // completion pulse this cycle
  bit          m_to    = 1'b0;
  bit          m_perr  = 1'b0;
  bit          m_wr    = 1'b0;
  logic [29:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be    = '0;
  logic [31:0] m_rd    = '0;
  int          m_age   = 0;
  bit          m_evt;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_busy = 0; m_cmd = 0; m_done = 0; m_to = 0; m_perr = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_be = '0; m_rd = '0; m_age = 0;
    end else begin
      if (bus_start && (m_busy || m_done)) m_perr = 1;
      if (m_done) begin
        m_done = 0; m_to = 0; m_rd = '0;
      end else if (!m_busy) begin
        if (bus_start) begin
          m_busy = 1; m_cmd = 1; m_age = 0;
          m_wr = bus_write; m_addr = bus_addr; m_wdata = bus_data_wr; m_be = bus_data_be;
        end
      end else begin
        m_evt = m_cmd ? !avl_waitrequest : avl_readdatavalid;
        if (m_evt && m_cmd && !m_wr) begin
          m_cmd = 0;
        end else if (m_evt) begin
          m_rd = m_cmd ? 32'h0 : avl_readdata;
          m_busy = 0; m_cmd = 0; m_done = 1; m_to = 0;
        end else if (TB_TIMEOUT != 0 && m_age == TB_TIMEOUT - 1) begin
          m_rd = 32'h0;
          m_busy = 0; m_cmd = 0; m_done = 1; m_to = 1;
        end
        if (m_age < 65535) m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_ready",   32'(bus_ready),    32'(m_done));
      chk("cmp_timeout", 32'(bus_timeout),  32'(m_done && m_to));
      chk("cmp_rdata",   bus_data_rd,       m_done ? m_rd : 32'h0);
      chk("cmp_perr",    32'(protocol_err), 32'(m_perr));
      chk("cmp_read",    32'(avl_read),     32'(m_cmd && !m_wr));
      chk("cmp_write",   32'(avl_write),    32'(m_cmd && m_wr));
      chk("cmp_addr",    avl_address,       {m_addr, 2'b00});
      chk("cmp_wdata",   avl_writedata,     m_wdata);
      chk("cmp_be",      32'(avl_byteenable), 32'(m_be));
      chk("cmp_excl",    32'(avl_read && avl_write), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a one-cycle request; returns in the first cycle after it is sampled.
  task automatic start(input logic wr, input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_start   = 1'b1;
    bus_write   = wr;
    bus_addr    = a;
    bus_data_wr = d;
    bus_data_be = be;
    tick();
    bus_start = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst0_ready", 32'(bus_ready), 32'h0);
    chk("rst0_addr", avl_address, 32'h0);
    chk("rst0_perr", 32'(protocol_err), 32'h0);
    tick();

    // Write, no stall: ready two cycles after start
    avl_waitrequest = 1'b0;
    start(1'b1, 30'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk("w_avl_write", 32'(avl_write), 32'h1);
    chk("w_addr", avl_address, 32'h40);
    chk("w_wdata", avl_writedata, 32'hDEADBEEF);
    chk("w_ready_early", 32'(bus_ready), 32'h0);
    tick();
    @(negedge clk);
    chk("w_ready", 32'(bus_ready), 32'h1);
    chk("w_write_drop", 32'(avl_write), 32'h0);
    chk("w_rd_zero", bus_data_rd, 32'h0);
    tick();
    @(negedge clk);
    chk("w_ready_once", 32'(bus_ready), 32'h0);
    tick();

    // Read, 3 stall cycles, acceptance coincides with the timeout cycle,
    // stray readdatavalid in the acceptance cycle, data two cycles later
    avl_waitrequest = 1'b1;
    start(1'b0, 30'h20, 32'h0, 4'h0);
    @(negedge clk);
    chk("r_avl_read", 32'(avl_read), 32'h1);
    chk("r_addr", avl_address, 32'h80);
    tick();
    tick();
    tick();
    avl_waitrequest   = 1'b0;
    avl_readdatavalid = 1'b1;
    avl_readdata      = 32'hBAD0BAD0;
    tick();
    avl_readdatavalid = 1'b0;
    @(negedge clk);
    chk("r_cmd_drop", 32'(avl_read), 32'h0);
    chk("r_no_early_ready", 32'(bus_ready), 32'h0);
    tick();
    avl_readdatavalid = 1'b1;
    avl_readdata      = 32'h12345678;
    tick();
    avl_readdatavalid = 1'b0;
    @(negedge clk);
    chk("r_ready", 32'(bus_ready), 32'h1);
    chk("r_data", bus_data_rd, 32'h12345678);
    chk("r_timeout", 32'(bus_timeout), 32'h0);
    tick();
    @(negedge clk);
    chk("r_ready_once", 32'(bus_ready), 32'h0);
    chk("r_data_clear", bus_data_rd, 32'h0);
    tick();

    // Back-to-back, then a start during RESP
    avl_waitrequest = 1'b0;
    start(1'b1, 30'h3, 32'h0000A5A5, 4'h3);
    tick();
    @(negedge clk);
    chk("bb_ready1", 32'(bus_ready), 32'h1);
    tick();
    start(1'b0, 30'h4, 32'h0, 4'h0);
    @(negedge clk);
    chk("bb_read", 32'(avl_read), 32'h1);
    chk("bb_perr0", 32'(protocol_err), 32'h0);
    tick();
    bus_start = 1'b1;
    bus_addr  = 30'h7;
    tick();
    bus_start = 1'b0;
    @(negedge clk);
    chk("bb_perr1", 32'(protocol_err), 32'h1);
    chk("bb_addr_held", avl_address, 32'h10);
    avl_readdatavalid = 1'b1;
    avl_readdata      = 32'hCAFEF00D;
    tick();
    avl_readdatavalid = 1'b0;
    @(negedge clk);
    chk("bb_ready2", 32'(bus_ready), 32'h1);
    chk("bb_data2", bus_data_rd, 32'hCAFEF00D);
    tick();

    // Read timeout in RESP, late readdatavalid ignored
    avl_waitrequest = 1'b0;
    start(1'b0, 30'h100, 32'h0, 4'h0);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("to_no_ready", 32'(bus_ready), 32'h0);
    tick();
    avl_readdatavalid = 1'b1;
    avl_readdata      = 32'hFEEDFACE;
    @(negedge clk);
    chk("to_ready", 32'(bus_ready), 32'h1);
    chk("to_flag", 32'(bus_timeout), 32'h1);
    chk("to_data", bus_data_rd, 32'h0);
    tick();
    @(negedge clk);
    chk("to_late_ignored", 32'(bus_ready), 32'h0);
    tick();
    avl_readdatavalid = 1'b0;

    // Write timeout in ISSUE (waitrequest never drops)
    avl_waitrequest = 1'b1;
    start(1'b1, 30'h200, 32'h11223344, 4'h5);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("ito_write_held", 32'(avl_write), 32'h1);
    tick();
    @(negedge clk);
    chk("ito_ready", 32'(bus_ready), 32'h1);
    chk("ito_flag", 32'(bus_timeout), 32'h1);
    chk("ito_write_drop", 32'(avl_write), 32'h0);
    tick();

    // Write accepted in the timeout cycle: completion wins
    avl_waitrequest = 1'b1;
    start(1'b1, 30'h300, 32'h00000055, 4'h1);
    tick();
    tick();
    tick();
    avl_waitrequest = 1'b0;
    tick();
    @(negedge clk);
    chk("co_ready", 32'(bus_ready), 32'h1);
    chk("co_timeout", 32'(bus_timeout), 32'h0);
    tick();

    // Reset during ISSUE with a start in the reset cycle
    avl_waitrequest = 1'b1;
    start(1'b0, 30'h40, 32'h0, 4'h0);
    @(negedge clk);
    chk("rst_read_before", 32'(avl_read), 32'h1);
    rst       = 1'b1;
    bus_start = 1'b1;
    bus_write = 1'b1;
    tick();
    rst       = 1'b0;
    bus_start = 1'b0;
    @(negedge clk);
    chk("rst_read_after", 32'(avl_read), 32'h0);
    chk("rst_write_after", 32'(avl_write), 32'h0);
    chk("rst_ready", 32'(bus_ready), 32'h0);
    chk("rst_perr", 32'(protocol_err), 32'h0);
    chk("rst_addr", avl_address, 32'h0);
    avl_readdatavalid = 1'b1;
    avl_readdata      = 32'h00000099;
    tick();
    avl_readdatavalid = 1'b0;
    @(negedge clk);
    chk("rst_late_ready", 32'(bus_ready), 32'h0);
    avl_waitrequest = 1'b0;
    start(1'b1, 30'h5, 32'h00000077, 4'hF);
    tick();
    @(negedge clk);
    chk("post_rst_ready", 32'(bus_ready), 32'h1);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
